// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, length constants, stall indices and
// length decode for the byte-wide RAM port arbiter.
package mem_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned LANE_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RD  = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } arb_state_e;

  localparam logic [CNT_W-1:0] LEN_B = 3'd1;
  localparam logic [CNT_W-1:0] LEN_H = 3'd2;
  localparam logic [CNT_W-1:0] LEN_W = 3'd4;

  // Bit positions in the stall controller's freeze vector.
  localparam int unsigned STALL_PC    = 0;
  localparam int unsigned STALL_IF_ID = 1;

  // Any length other than 1 or 2 bytes is a full word.
  function automatic logic [CNT_W-1:0] len_bytes(input logic [CNT_W-1:0] len);
    case (len)
      LEN_B:   len_bytes = LEN_B;
      LEN_H:   len_bytes = LEN_H;
      default: len_bytes = LEN_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_assemble.sv
// mem_arb_assemble: byte-lane shift-in register shared by IF and MEM reads.
// word_c already contains the byte being loaded this cycle so the caller can
// register the finished word on the same edge as the last byte.
module mem_arb_assemble
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [LANE_W-1:0] lane,
  input  logic [BYTE_W-1:0] din,
  output logic [DATA_W-1:0] word_c
);

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] merged;

  // Merge the incoming byte into its lane; untouched lanes stay zero after clr.
  always_comb begin
    merged = acc;
    if (load) begin
      merged[{lane, 3'b000} +: BYTE_W] = din;
    end
  end

  // Accumulator: cleared at the start of every read.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else begin
      acc <= merged;
    end
  end

  assign word_c = merged;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises IF word fetches and MEM 1/2/4-byte loads/stores onto
// a single byte-wide synchronous RAM port. MEM has priority; a taken branch
// cancels an in-flight fetch. Optional tracing under MEM_ARB_TRACE_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              branch_or_not,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_done,
  output logic              if_stall_req,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [CNT_W-1:0]  mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              mem_stall_req,
  input  logic [BYTE_W-1:0] ram_din,
  output logic [BYTE_W-1:0] ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  arb_state_e        state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [CNT_W-1:0]  nbytes_q, nbytes_n;
  logic [ADDR_W-1:0] base_q, base_n;
  logic [ADDR_W-1:0] ram_a_q, ram_a_n;
  logic [BYTE_W-1:0] ram_dout_q, ram_dout_n;
  logic              ram_wr_q, ram_wr_n;
  logic [DATA_W-1:0] if_data_q, if_data_n;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_n;
  logic              if_done_q, if_done_n;
  logic              mem_done_q, mem_done_n;

  logic              asm_clr, asm_load;
  logic [LANE_W-1:0] asm_lane;
  logic [DATA_W-1:0] asm_word;
  logic [BYTE_W-1:0] wr_byte;
  logic              last_rd;

  // cnt counts addresses issued; data for byte k arrives when cnt == k+2.
  assign asm_lane = LANE_W'(cnt_q - 3'd2);
  assign last_rd  = (cnt_q == CNT_W'(nbytes_q + 3'd1));
  assign wr_byte  = BYTE_W'(mem_wdata >> {cnt_q[1:0], 3'b000});

  mem_arb_assemble u_assemble (
    .clk    (clk_in),
    .rst    (rst_in),
    .clr    (asm_clr),
    .load   (asm_load),
    .lane   (asm_lane),
    .din    (ram_din),
    .word_c (asm_word)
  );

  // State register and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      nbytes_q    <= '0;
      base_q      <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      nbytes_q    <= nbytes_n;
      base_q      <= base_n;
      ram_a_q     <= ram_a_n;
      ram_dout_q  <= ram_dout_n;
      ram_wr_q    <= ram_wr_n;
      if_data_q   <= if_data_n;
      mem_rdata_q <= mem_rdata_n;
      if_done_q   <= if_done_n;
      mem_done_q  <= mem_done_n;
    end
  end

  // Next-state and next-output logic; everything holds while rdy_in is low.
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    nbytes_n    = nbytes_q;
    base_n      = base_q;
    ram_a_n     = ram_a_q;
    ram_dout_n  = ram_dout_q;
    ram_wr_n    = ram_wr_q;
    if_data_n   = if_data_q;
    mem_rdata_n = mem_rdata_q;
    if_done_n   = if_done_q;
    mem_done_n  = mem_done_q;
    asm_clr     = 1'b0;
    asm_load    = 1'b0;

    if (rdy_in) begin
      if_done_n  = 1'b0;
      mem_done_n = 1'b0;
      ram_wr_n   = 1'b0;
      case (state_q)
        IDLE: begin
          // The done cycle still sees the finished request held high.
          if (!if_done_q && !mem_done_q) begin
            if (mem_req) begin
              base_n   = mem_addr;
              nbytes_n = len_bytes(mem_len);
              ram_a_n  = mem_addr;
              cnt_n    = 3'd1;
              asm_clr  = 1'b1;
              if (mem_we) begin
                state_n    = MEM_WR;
                ram_dout_n = mem_wdata[BYTE_W-1:0];
                ram_wr_n   = 1'b1;
              end else begin
                state_n = MEM_RD;
              end
            end else if (if_req && !branch_or_not) begin
              base_n   = if_addr;
              nbytes_n = LEN_W;
              ram_a_n  = if_addr;
              cnt_n    = 3'd1;
              asm_clr  = 1'b1;
              state_n  = IF_RD;
            end
          end
        end
        IF_RD, MEM_RD: begin
          if (state_q == IF_RD && branch_or_not) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + 3'd1;
            if (cnt_q < nbytes_q) begin
              ram_a_n = base_q + ADDR_W'(cnt_q);
            end
            if (cnt_q >= 3'd2) begin
              asm_load = 1'b1;
            end
            if (last_rd) begin
              state_n = IDLE;
              cnt_n   = '0;
              if (state_q == IF_RD) begin
                if_done_n = 1'b1;
                if_data_n = asm_word;
              end else begin
                mem_done_n  = 1'b1;
                mem_rdata_n = asm_word;
              end
            end
          end
        end
        MEM_WR: begin
          if (cnt_q < nbytes_q) begin
            ram_a_n    = base_q + ADDR_W'(cnt_q);
            ram_dout_n = wr_byte;
            ram_wr_n   = 1'b1;
            cnt_n      = cnt_q + 3'd1;
          end else begin
            state_n    = IDLE;
            cnt_n      = '0;
            mem_done_n = 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign ram_a         = ram_a_q;
  assign ram_dout      = ram_dout_q;
  assign ram_wr        = ram_wr_q & rdy_in;
  assign if_data       = if_data_q;
  assign if_done       = if_done_q & ~branch_or_not;
  assign mem_rdata     = mem_rdata_q;
  assign mem_done      = mem_done_q;
  assign if_stall_req  = if_req & ~if_done;
  assign mem_stall_req = mem_req & ~mem_done;

`ifdef MEM_ARB_TRACE_EN
  logic [31:0] if_xact_cnt;
  logic [31:0] mem_xact_cnt;
  logic [31:0] cancel_cnt;

  // Transaction and cancellation counters with a trace line per completion.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      if_xact_cnt  <= '0;
      mem_xact_cnt <= '0;
      cancel_cnt   <= '0;
    end else if (rdy_in) begin
      if (if_done_n) begin
        if_xact_cnt <= if_xact_cnt + 32'd1;
        $display("mem_arb: IF  addr=%h data=%h", base_q, if_data_n);
      end
      if (mem_done_n) begin
        mem_xact_cnt <= mem_xact_cnt + 32'd1;
        $display("mem_arb: %s addr=%h data=%h", (state_q == MEM_WR) ? "ST " : "LD ",
                 base_q, (state_q == MEM_WR) ? mem_wdata : mem_rdata_n);
      end
      if (state_q == IF_RD && branch_or_not) begin
        cancel_cnt <= cancel_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand-written corner sequences
// against a small synchronous byte RAM model.
module tb_mem_arbiter;

  localparam int K_IF = 0;
  localparam int K_LD = 1;
  localparam int K_ST = 2;
  localparam int NV   = 15;

  logic        clk = 1'b0;
  logic        rst, rdy, branch;
  logic        if_req, if_done, if_stall_req;
  logic [31:0] if_addr, if_data;
  logic        mem_req, mem_we, mem_done, mem_stall_req;
  logic [2:0]  mem_len;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  ram_din, ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram [0:1023];

  int n_pass   = 0;
  int n_checks = 0;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [2:0]  len;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [NV];

  mem_arbiter dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .rdy_in        (rdy),
    .branch_or_not (branch),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_data       (if_data),
    .if_done       (if_done),
    .if_stall_req  (if_stall_req),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_len       (mem_len),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_done      (mem_done),
    .mem_stall_req (mem_stall_req),
    .ram_din       (ram_din),
    .ram_dout      (ram_dout),
    .ram_a         (ram_a),
    .ram_wr        (ram_wr)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM, paused while rdy is low.
  always @(posedge clk) begin
    if (rdy) begin
      if (ram_wr) ram[ram_a[9:0]] <= ram_dout;
      ram_din <= ram[ram_a[9:0]];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, got, exp);
  endtask

  // Issue one request and follow it to its done pulse (bounded).
  task automatic run_xact(input int kind, input logic [31:0] addr, input logic [2:0] len,
                          input logic [31:0] wdata, output logic [31:0] data,
                          output int lat, output bit seq_ok, output bit stall_ok);
    int          nb;
    logic [31:0] wsh;
    logic        d, st;
    nb = (kind == K_IF) ? 4 : (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
    data = '0; lat = 0; seq_ok = 1'b1; stall_ok = 1'b1;
    if (kind == K_IF) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      mem_req = 1'b1; mem_we = (kind == K_ST); mem_len = len;
      mem_addr = addr; mem_wdata = wdata;
    end
    for (int c = 1; c <= 40; c++) begin
      tick();
      d  = (kind == K_IF) ? if_done : mem_done;
      st = (kind == K_IF) ? if_stall_req : mem_stall_req;
      if (st !== ~d) stall_ok = 1'b0;
      if (c <= nb) begin
        if (ram_a !== addr + 32'(c - 1)) seq_ok = 1'b0;
        wsh = wdata >> (8 * (c - 1));
        if (kind == K_ST) begin
          if (ram_wr !== 1'b1 || ram_dout !== wsh[7:0]) seq_ok = 1'b0;
        end else if (ram_wr !== 1'b0) seq_ok = 1'b0;
      end else if (ram_wr !== 1'b0) seq_ok = 1'b0;
      if (d === 1'b1) begin
        lat  = c;
        data = (kind == K_IF) ? if_data : mem_rdata;
        break;
      end
    end
    if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
  endtask

  initial begin
    logic [31:0] data, got_m, got_i, a4;
    int          lat, mem_at, if_at;
    bit          seq_ok, stall_ok, wr_seen, done_seen;

    vecs[0]  = '{K_IF, 32'h010, 3'd4, 32'h0,         32'h0000_0513, 6};
    vecs[1]  = '{K_LD, 32'h100, 3'd4, 32'h0,         32'h0403_0201, 6};
    vecs[2]  = '{K_LD, 32'h103, 3'd1, 32'h0,         32'h0000_0004, 3};
    vecs[3]  = '{K_LD, 32'h101, 3'd2, 32'h0,         32'h0000_0302, 4};
    vecs[4]  = '{K_ST, 32'h200, 3'd2, 32'hAABB_CCDD, 32'h0,         3};
    vecs[5]  = '{K_LD, 32'h200, 3'd4, 32'h0,         32'h0000_CCDD, 6};
    vecs[6]  = '{K_ST, 32'h204, 3'd1, 32'h1234_5678, 32'h0,         2};
    vecs[7]  = '{K_ST, 32'h208, 3'd4, 32'hDEAD_BEEF, 32'h0,         5};
    vecs[8]  = '{K_LD, 32'h208, 3'd4, 32'h0,         32'hDEAD_BEEF, 6};
    vecs[9]  = '{K_LD, 32'h100, 3'd3, 32'h0,         32'h0403_0201, 6};
    vecs[10] = '{K_ST, 32'h20C, 3'd0, 32'h0102_0304, 32'h0,         5};
    vecs[11] = '{K_LD, 32'h20F, 3'd1, 32'h0,         32'h0000_0001, 3};
    vecs[12] = '{K_LD, 32'h204, 3'd2, 32'h0,         32'h0000_0078, 4};
    vecs[13] = '{K_IF, 32'h020, 3'd4, 32'h0,         32'h0040_006F, 6};
    vecs[14] = '{K_LD, 32'h1FF, 3'd2, 32'h0,         32'h0000_DD00, 4};

    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[16] = 8'h13; ram[17] = 8'h05;
    ram[32] = 8'h6F; ram[34] = 8'h40;
    ram[256] = 8'h01; ram[257] = 8'h02; ram[258] = 8'h03; ram[259] = 8'h04;
    ram_din = 8'h00;

    rst = 1'b1; rdy = 1'b1; branch = 1'b0;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_len = 3'd0; mem_addr = '0; mem_wdata = '0;
    repeat (3) tick();
    chk("reset ram_a", ram_a, 32'h0);
    chk("reset ram_dout_wr", {23'h0, ram_dout, ram_wr}, 32'h0);
    chk("reset data", if_data | mem_rdata, 32'h0);
    chk("reset done_stall", {28'h0, if_done, mem_done, if_stall_req, mem_stall_req}, 32'h0);
    rst = 1'b0;
    tick();

    // Directed vector table.
    for (int i = 0; i < NV; i++) begin
      run_xact(vecs[i].kind, vecs[i].addr, vecs[i].len, vecs[i].wdata,
               data, lat, seq_ok, stall_ok);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (vecs[i].kind != K_ST) chk($sformatf("v%0d data", i), data, vecs[i].exp_data);
      chk($sformatf("v%0d ram sequence", i), {31'h0, seq_ok}, 32'h1);
      chk($sformatf("v%0d stall", i), {31'h0, stall_ok}, 32'h1);
      tick();
      chk($sformatf("v%0d single pulse", i), {30'h0, if_done, mem_done}, 32'h0);
    end

    // Simultaneous IF and MEM requests: MEM wins, IF follows.
    if_req = 1'b1; if_addr = 32'h10;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 3'd4; mem_addr = 32'h100;
    mem_at = 0; if_at = 0; stall_ok = 1'b1; a4 = '0; got_m = '0; got_i = '0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) a4 = ram_a;
      if (if_done === 1'b1) begin
        if_at = c; got_i = if_data; if_req = 1'b0;
        break;
      end
      if (if_stall_req !== 1'b1) stall_ok = 1'b0;
      if (mem_done === 1'b1 && mem_at == 0) begin
        mem_at = c; got_m = mem_rdata; mem_req = 1'b0;
      end
    end
    chk("prio first addr", a4, 32'h100);
    chk("prio mem latency", 32'(mem_at), 32'd6);
    chk("prio mem data", got_m, 32'h0403_0201);
    chk("prio if after mem", {31'h0, (if_at > mem_at) && (mem_at > 0)}, 32'h1);
    chk("prio if data", got_i, 32'h0000_0513);
    chk("prio if stall", {31'h0, stall_ok}, 32'h1);
    tick();

    // Branch two cycles into a fetch cancels it; refetch at the new address.
    if_req = 1'b1; if_addr = 32'h10;
    tick(); tick();
    branch = 1'b1; if_addr = 32'h20;
    tick();
    branch = 1'b0;
    chk("cancel no done", {31'h0, if_done}, 32'h0);
    lat = 0; a4 = '0; got_i = '0;
    for (int c = 4; c <= 40; c++) begin
      tick();
      if (c == 4) a4 = ram_a;
      if (if_done === 1'b1) begin
        lat = c; got_i = if_data; if_req = 1'b0;
        break;
      end
    end
    chk("cancel refetch addr", a4, 32'h20);
    chk("cancel refetch latency", 32'(lat), 32'd9);
    chk("cancel refetch data", got_i, 32'h0040_006F);
    tick();

    // Branch coincident with the done cycle masks if_done.
    if_req = 1'b1; if_addr = 32'h10;
    repeat (6) tick();
    branch = 1'b1;
    #1;
    chk("branch masks done", {31'h0, if_done}, 32'h0);
    branch = 1'b0;
    #1;
    chk("done unmasked", {31'h0, if_done}, 32'h1);
    if_req = 1'b0;
    tick(); tick();

    // rdy low for 3 cycles during a 4-byte load.
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 3'd4; mem_addr = 32'h100;
    tick(); tick();
    rdy = 1'b0;
    lat = 0; wr_seen = 1'b0; a4 = '0; got_m = '0;
    for (int c = 3; c <= 40; c++) begin
      tick();
      if (c == 4) a4 = ram_a;
      if (c == 5) rdy = 1'b1;
      if (ram_wr !== 1'b0) wr_seen = 1'b1;
      if (mem_done === 1'b1) begin
        lat = c; got_m = mem_rdata; mem_req = 1'b0;
        break;
      end
    end
    chk("rdy load addr held", a4, 32'h101);
    chk("rdy load no wr", {31'h0, wr_seen}, 32'h0);
    chk("rdy load latency", 32'(lat), 32'd9);
    chk("rdy load data", got_m, 32'h0403_0201);
    tick();

    // rdy low for 2 cycles during a 4-byte store gates ram_wr.
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 3'd4; mem_addr = 32'h210; mem_wdata = 32'h5566_7788;
    tick(); tick();
    rdy = 1'b0;
    #1;
    chk("rdy store wr gated", {31'h0, ram_wr}, 32'h0);
    lat = 0;
    for (int c = 3; c <= 40; c++) begin
      tick();
      if (c == 4) rdy = 1'b1;
      if (mem_done === 1'b1) begin
        lat = c; mem_req = 1'b0; mem_we = 1'b0;
        break;
      end
    end
    chk("rdy store latency", 32'(lat), 32'd7);
    tick();
    run_xact(K_LD, 32'h210, 3'd4, 32'h0, data, lat, seq_ok, stall_ok);
    chk("rdy store readback", data, 32'h5566_7788);
    tick();

    // Reset in the middle of a store.
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 3'd4; mem_addr = 32'h300; mem_wdata = 32'h1122_3344;
    tick(); tick();
    chk("mid store writing", {31'h0, ram_wr}, 32'h1);
    rst = 1'b1;
    tick();
    chk("rst ram_a", ram_a, 32'h0);
    chk("rst ram_dout_wr", {23'h0, ram_dout, ram_wr}, 32'h0);
    chk("rst data", if_data | mem_rdata, 32'h0);
    chk("rst done", {30'h0, if_done, mem_done}, 32'h0);
    rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    done_seen = 1'b0;
    repeat (5) begin
      tick();
      if (mem_done !== 1'b0 || ram_wr !== 1'b0) done_seen = 1'b1;
    end
    chk("rst no done", {31'h0, done_seen}, 32'h0);
    run_xact(K_LD, 32'h300, 3'd4, 32'h0, data, lat, seq_ok, stall_ok);
    chk("rst next latency", 32'(lat), 32'd6);
    chk("rst partial data", data, 32'h0000_3344);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
